// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve
//   Registered consumer for the EX-stage ALU outputs. It captures one ALU beat
//   per valid/ready handshake and forwards it to the EX/MEM register. It also
//   resolves conditional branches from the ALU flags, emits a one-cycle
//   redirect to IF/ID, and then discards a fixed number of wrong-path beats.
//
// Parameters
//   SQUASH_BEATS : accepted input beats discarded after a taken branch (1..15)
//   CNT_W        : width of the taken-branch counter
//
// Ports
//   clk, reset              : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready     : input handshake
//   Result, zero, Great     : ALU result and flags (a-b for branches)
//   Branch, funct3          : conditional-branch marker and condition
//   br_target               : precomputed PC+imm
//   rd, RegWrite, MemRead,
//   MemWrite, rs2_data      : fields passed through to EX/MEM
//   out_valid / out_ready   : output handshake
//   out_result, out_rs2,
//   out_rd, out_RegWrite,
//   out_MemRead, out_MemWrite : registered beat
//   redirect, redirect_pc   : one-cycle taken-branch pulse and its target
//   flag_err                : sticky, set when zero and Great agreed on an accept
//   taken_cnt               : taken branches since reset, wraps
module ex_branch_resolve #(
  parameter int SQUASH_BEATS = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      Result,
  input  logic             zero,
  input  logic             Great,
  input  logic             Branch,
  input  logic [2:0]       funct3,
  input  logic [63:0]      br_target,
  input  logic [4:0]       rd,
  input  logic             RegWrite,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [63:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [63:0]      out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_RegWrite,
  output logic             out_MemRead,
  output logic             out_MemWrite,
  output logic             redirect,
  output logic [63:0]      redirect_pc,
  output logic             flag_err,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [3:0] SQ_INIT = 4'(SQUASH_BEATS);

  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_SQUASH = 1'b1
  } state_t;

  state_t     state, state_next;
  logic [3:0] sq_cnt, sq_cnt_next;

  logic accept;
  logic discard;
  logic cond_true;
  logic taken;

  // Branch condition from the flags of a-b. Signed overflow is deliberately
  // ignored, so BLT/BGE look only at the sign bit of the difference.
  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      3'b000:  cond_true = zero;
      3'b001:  cond_true = Great;
      3'b100:  cond_true = Result[63];
      3'b101:  cond_true = !Result[63];
      default: cond_true = 1'b0;
    endcase
  end

  assign accept  = in_valid && in_ready && (state == ST_PASS);
  assign discard = in_valid && (state == ST_SQUASH);
  assign taken   = accept && Branch && cond_true;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_PASS;
      sq_cnt <= 4'd0;
    end else begin
      state  <= state_next;
      sq_cnt <= sq_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state;
    sq_cnt_next = sq_cnt;
    case (state)
      ST_PASS: begin
        if (taken) begin
          state_next  = ST_SQUASH;
          sq_cnt_next = SQ_INIT;
        end
      end
      ST_SQUASH: begin
        if (discard) begin
          sq_cnt_next = sq_cnt - 4'd1;
          // The beat that brings the count to zero is itself discarded.
          // "<=" also recovers if the count were ever found at zero.
          if (sq_cnt <= 4'd1) begin
            state_next  = ST_PASS;
            sq_cnt_next = 4'd0;
          end
        end
      end
      default: begin
        state_next  = ST_PASS;
        sq_cnt_next = 4'd0;
      end
    endcase
  end

  // Output logic: SQUASH always swallows input, independent of output stalls.
  always_comb begin
    in_ready = 1'b1;
    if (state == ST_PASS) begin
      in_ready = !out_valid || out_ready;
    end
  end

  // Output beat register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_result   <= 64'd0;
      out_rs2      <= 64'd0;
      out_rd       <= 5'd0;
      out_RegWrite <= 1'b0;
      out_MemRead  <= 1'b0;
      out_MemWrite <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_result   <= Result;
      out_rs2      <= rs2_data;
      out_rd       <= rd;
      out_RegWrite <= RegWrite;
      out_MemRead  <= MemRead;
      out_MemWrite <= MemWrite;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Redirect pulse, error flag and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect    <= 1'b0;
      redirect_pc <= 64'd0;
      flag_err    <= 1'b0;
      taken_cnt   <= '0;
    end else begin
      redirect    <= taken;
      redirect_pc <= taken ? br_target : 64'd0;
      if (accept && (zero == Great)) begin
        flag_err <= 1'b1;
      end
      if (taken) begin
        taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_ex_branch_resolve.sv
module tb_ex_branch_resolve;

  localparam int SQ = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] Result = '0;
  logic        zero = 1'b0;
  logic        Great = 1'b0;
  logic        Branch = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [63:0] br_target = '0;
  logic [4:0]  rd = '0;
  logic        RegWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [63:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [63:0] out_rs2;
  logic [4:0]  out_rd;
  logic        out_RegWrite;
  logic        out_MemRead;
  logic        out_MemWrite;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        flag_err;
  logic [31:0] taken_cnt;

  ex_branch_resolve #(.SQUASH_BEATS(SQ), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .Result(Result), .zero(zero), .Great(Great),
    .Branch(Branch), .funct3(funct3), .br_target(br_target),
    .rd(rd), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_RegWrite(out_RegWrite), .out_MemRead(out_MemRead), .out_MemWrite(out_MemWrite),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flag_err(flag_err), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Input record plus the hand-derived expectation "branch is taken if it
  // gets evaluated" (only honoured when the beat is accepted in PASS).
  typedef struct {
    logic        v;
    logic [63:0] res;
    logic        z;
    logic        g;
    logic        br;
    logic [2:0]  f3;
    logic [63:0] tgt;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [63:0] rs2;
    logic        ordy;
    logic        exp_taken;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  ctl;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  int checks = 0;
  int errors = 0;
  int beat_no = 0;

  // Bench model state
  logic        m_ov = 1'b0;
  logic        m_redir = 1'b0;
  logic [63:0] m_pc = '0;
  logic [31:0] m_cnt = '0;
  logic        m_err = 1'b0;
  logic        m_sq = 1'b0;
  int          m_sqn = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s beat=%0d actual=%h expected=%h", name, beat_no, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [63:0] res, input logic z, input logic g,
                              input logic br, input logic [2:0] f3, input logic [63:0] tgt,
                              input int rdi, input logic rw, input logic mr, input logic mw,
                              input logic [63:0] rs2, input logic ordy, input logic tk);
    vec_t t;
    t.v = v; t.res = res; t.z = z; t.g = g; t.br = br; t.f3 = f3; t.tgt = tgt;
    t.rd = 5'(rdi); t.rw = rw; t.mr = mr; t.mw = mw; t.rs2 = rs2; t.ordy = ordy;
    t.exp_taken = tk;
    return t;
  endfunction

  // Consistent-flag ALU beat
  function automatic vec_t plain(input logic [63:0] res, input int rdi, input logic ordy);
    return mk(1'b1, res, res == 64'd0, res != 64'd0, 1'b0, 3'd0, 64'd0, rdi, 1'b1, 1'b0, 1'b0,
              res ^ 64'hA5A5_0000_0000_5A5A, ordy, 1'b0);
  endfunction

  function automatic vec_t bra(input logic [2:0] f3, input logic [63:0] res, input logic z,
                               input logic g, input logic [63:0] tgt, input logic tk,
                               input logic ordy);
    return mk(1'b1, res, z, g, 1'b1, f3, tgt, 0, 1'b0, 1'b0, 1'b0, 64'd0, ordy, tk);
  endfunction

  function automatic vec_t idle(input logic ordy);
    return mk(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0, 0, 1'b0, 1'b0, 1'b0, 64'd0, ordy, 1'b0);
  endfunction

  // One clock cycle: drive at the falling edge, check 1 ns later, advance model.
  task automatic step(input vec_t t);
    logic exp_rdy, acc, disc, tk;
    sb_t  e;
    @(negedge clk);
    in_valid = t.v; Result = t.res; zero = t.z; Great = t.g; Branch = t.br;
    funct3 = t.f3; br_target = t.tgt; rd = t.rd; RegWrite = t.rw; MemRead = t.mr;
    MemWrite = t.mw; rs2_data = t.rs2; out_ready = t.ordy;
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("redirect", 64'(redirect), 64'(m_redir));
    if (m_redir) chk("redirect_pc", redirect_pc, m_pc);
    chk("taken_cnt", 64'(taken_cnt), 64'(m_cnt));
    chk("flag_err", 64'(flag_err), 64'(m_err));
    exp_rdy = m_sq ? 1'b1 : (!m_ov || t.ordy);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (m_ov && t.ordy) begin
      if (sbq.size() == 0) begin
        chk("scoreboard_empty", 64'(1), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_rs2", out_rs2, e.rs2);
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_ctl", 64'({out_RegWrite, out_MemRead, out_MemWrite}), 64'(e.ctl));
      end
    end
    acc  = t.v && exp_rdy && !m_sq;
    disc = t.v && m_sq;
    tk   = acc && t.br && t.exp_taken;
    m_redir = tk;
    if (tk) begin
      m_pc = t.tgt;
      m_cnt = m_cnt + 32'd1;
      m_sq = 1'b1;
      m_sqn = SQ;
    end else if (disc) begin
      m_sqn--;
      if (m_sqn == 0) m_sq = 1'b0;
    end
    if (acc && (t.z == t.g)) m_err = 1'b1;
    if (acc) begin
      e.res = t.res; e.rs2 = t.rs2; e.rd = t.rd; e.ctl = {t.rw, t.mr, t.mw};
      sbq.push_back(e);
    end
    m_ov = acc ? 1'b1 : (t.ordy ? 1'b0 : m_ov);
    $display("beat %0d: valid=%0b ordy=%0b accepted=%0b discarded=%0b taken=%0b",
             beat_no, t.v, t.ordy, acc, disc, tk);
    beat_no++;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_result"}, out_result, 64'd0);
    chk({tag, "_out_rs2"}, out_rs2, 64'd0);
    chk({tag, "_out_rd_ctl"}, 64'({out_rd, out_RegWrite, out_MemRead, out_MemWrite}), 64'd0);
    chk({tag, "_redirect"}, 64'(redirect), 64'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 64'd0);
    chk({tag, "_flag_err"}, 64'(flag_err), 64'd0);
    chk({tag, "_taken_cnt"}, 64'(taken_cnt), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_state(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_ov = 1'b0; m_redir = 1'b0; m_pc = '0; m_cnt = '0; m_err = 1'b0;
    m_sq = 1'b0; m_sqn = 0;
    sbq.delete();
  endtask

  initial begin
    // Stimulus table
    vecs.push_back(plain(64'h5, 3, 1'b1));
    vecs.push_back(bra(3'b000, 64'd0, 1'b1, 1'b0, 64'h1000, 1'b1, 1'b1));      // BEQ taken
    vecs.push_back(plain(64'h22, 4, 1'b1));                                     // discarded
    vecs.push_back(plain(64'h33, 5, 1'b1));                                     // discarded
    vecs.push_back(plain(64'h44, 6, 1'b1));                                     // passes
    vecs.push_back(bra(3'b100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'h2000, 1'b1, 1'b1)); // BLT
    vecs.push_back(idle(1'b1));                                                 // no decrement
    vecs.push_back(bra(3'b000, 64'd0, 1'b1, 1'b0, 64'h9999, 1'b1, 1'b1));      // discarded, not evaluated
    vecs.push_back(plain(64'h77, 12, 1'b1));                                    // discarded
    vecs.push_back(mk(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 3'b101, 64'h2100,
                      9, 1'b0, 1'b0, 1'b1, 64'hBEEF, 1'b1, 1'b0));              // BGE not taken
    vecs.push_back(plain(64'h88, 7, 1'b1));
    vecs.push_back(bra(3'b001, 64'h7, 1'b0, 1'b1, 64'h3000, 1'b1, 1'b1));      // BNE taken
    vecs.push_back(plain(64'h91, 13, 1'b1));
    vecs.push_back(plain(64'h92, 14, 1'b1));
    vecs.push_back(bra(3'b001, 64'd0, 1'b1, 1'b0, 64'h3100, 1'b0, 1'b1));      // BNE not taken
    vecs.push_back(bra(3'b010, 64'h5, 1'b0, 1'b1, 64'h3200, 1'b0, 1'b1));      // other funct3
    vecs.push_back(bra(3'b000, 64'h3, 1'b0, 1'b1, 64'h3300, 1'b0, 1'b1));      // BEQ not taken
    vecs.push_back(bra(3'b100, 64'h5, 1'b0, 1'b1, 64'h3400, 1'b0, 1'b1));      // BLT not taken
    vecs.push_back(bra(3'b101, 64'd0, 1'b1, 1'b0, 64'h4000, 1'b1, 1'b1));      // BGE taken
    vecs.push_back(plain(64'hA1, 15, 1'b1));
    vecs.push_back(plain(64'hA2, 16, 1'b1));
    vecs.push_back(idle(1'b1));
    // Output stall: only the first of three offered beats is captured
    vecs.push_back(plain(64'hB1, 8, 1'b0));
    vecs.push_back(plain(64'hB2, 17, 1'b0));
    vecs.push_back(plain(64'hB3, 18, 1'b0));
    vecs.push_back(idle(1'b0));
    vecs.push_back(plain(64'hB4, 9, 1'b1));                                     // accept + drain
    vecs.push_back(idle(1'b1));
    // Taken branch while the output stalls; discards go on regardless
    vecs.push_back(bra(3'b000, 64'd0, 1'b1, 1'b0, 64'h5000, 1'b1, 1'b0));
    vecs.push_back(plain(64'hC1, 19, 1'b0));
    vecs.push_back(plain(64'hC2, 20, 1'b0));
    vecs.push_back(plain(64'hC3, 10, 1'b0));                                    // back in PASS, stalled
    vecs.push_back(plain(64'hC4, 11, 1'b1));
    vecs.push_back(idle(1'b1));

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) step(vecs[i]);

    // Sticky flag_err, cleared only by asynchronous reset
    step(mk(1'b1, 64'h1, 1'b1, 1'b1, 1'b0, 3'd0, 64'd0, 21, 1'b1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0));
    for (int k = 0; k < 10; k++) step(plain(64'(k + 1), k + 1, 1'b1));
    step(idle(1'b1));
    pulse_reset("err_reset");

    // Reset in the middle of a squash
    step(bra(3'b000, 64'd0, 1'b1, 1'b0, 64'h6000, 1'b1, 1'b1));
    step(plain(64'hD1, 22, 1'b1));
    pulse_reset("squash_reset");
    step(plain(64'hD2, 23, 1'b1));
    step(idle(1'b1));
    step(idle(1'b1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_branch_resolve.md
# ex_branch_resolve

Registered consumer for the 64-bit EX-stage ALU outputs (Result, zero, Great). It sits between the ALU and the EX/MEM pipeline register. It captures each ALU beat with a valid/ready handshake, resolves conditional branches from the ALU flags and funct3, and drives a one-cycle redirect/flush to IF/ID. After a taken branch it squashes a fixed number of wrong-path beats.

## Interface
- SQUASH_BEATS, 2: number of accepted input beats discarded after a taken branch (1..15).
- CNT_W, 32: width of the taken-branch statistics counter.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- Result  input  64  ALU result; for branches the ALU executes a-b (ALUop 0110).
- zero  input  1  ALU zero flag.
- Great  input  1  ALU "Result > 0 unsigned" flag.
- Branch  input  1  beat is a conditional branch.
- funct3  input  3  branch condition.
- br_target  input  64  precomputed PC+imm.
- rd  input  5  destination register.
- RegWrite, MemRead, MemWrite  input  1 each  control bits, passed through.
- rs2_data  input  64  store data, passed through.
- out_valid  output  1  EX/MEM beat valid.
- out_ready  input  1  downstream accepts.
- out_result, out_rs2  output  64 each  registered Result / rs2_data.
- out_rd  output  5; out_RegWrite, out_MemRead, out_MemWrite  output  1 each.
- redirect  output  1  one-cycle taken-branch pulse.
- redirect_pc  output  64  target, valid while redirect=1.
- flag_err  output  1  sticky: zero and Great were inconsistent.
- taken_cnt  output  CNT_W  taken branches since reset, wraps.

## Operation
- States: PASS, SQUASH. Squash counter sq_cnt is 4 bits.
- PASS: in_ready = !out_valid || out_ready. An accept (in_valid && in_ready) loads all out_* fields and sets out_valid.
- Without an accept, out_valid clears when out_ready=1; otherwise out_* hold.
- Branch condition at accept, only when Branch=1:
  - funct3 000 (BEQ): taken = zero.
  - 001 (BNE): taken = Great.
  - 100 (BLT): taken = Result[63].
  - 101 (BGE): taken = !Result[63].
  - Any other funct3: not taken.
  - Signed overflow of a-b is ignored (decided).
- Branch beats are forwarded with RegWrite/MemRead/MemWrite as supplied.
- Taken at accept:
  - redirect=1 and redirect_pc=br_target on the next cycle, for exactly one cycle.
  - taken_cnt increments.
  - Next state is SQUASH with sq_cnt=SQUASH_BEATS.
- SQUASH:
  - in_ready=1. Each beat with in_valid=1 is discarded: no output load, no branch evaluation, sq_cnt decrements.
  - sq_cnt reaching 0 returns the state to PASS. The beat that takes sq_cnt to 0 is also discarded.
  - out_valid/out_* drain normally via out_ready.
- flag_err: set on any accept in PASS where zero == Great. Cleared only by reset.
- taken_cnt wraps from all-ones to 0.

## Timing
- Reset (reset=0, asynchronous): state=PASS, sq_cnt=0, out_valid=0, all out_* = 0, redirect=0, redirect_pc=0, flag_err=0, taken_cnt=0, in_ready=1.
- Latency: accept at edge N → out_valid/out_* and redirect visible after edge N, i.e. in cycle N+1.
- redirect is a pulse and is not held while out_valid stalls under out_ready=0.
- Accept and drain in the same cycle (out_valid && out_ready && in_valid): the new beat replaces the old one, out_valid stays 1, no bubble.
- Taken branch accepted while output stalls: in_ready=0 follows, yet SQUASH has in_ready=1 next cycle. Discards proceed independently of the output stall.
- Reset asserted mid-SQUASH: immediate return to PASS. Pending redirect is dropped.

## Test plan
- Plain ALU beat, Result=0x5, rd=3, RegWrite=1, out_ready=1 → next cycle out_valid=1, out_result=0x5, out_rd=3. No redirect.
- BEQ with Result=0, zero=1, Great=0, br_target=0x1000 → redirect=1 for one cycle, redirect_pc=0x1000, taken_cnt=1. The next 2 valid beats are dropped; the 3rd beat appears on the output.
- BLT with Result=0xFFFF_FFFF_FFFF_FFFE → taken. BGE with the same Result → not taken, no squash.
- out_ready=0 for 4 cycles with 3 beats offered → only the first is captured, in_ready=0 while stalled. Releasing out_ready passes the next beat with no bubble.
- Beat with zero=1, Great=1 → flag_err=1, still 1 after 10 further clean beats. reset=0 clears it asynchronously.
- Taken branch, then reset=0 pulsed after 1 discarded beat → all outputs 0. The next valid beat is accepted in PASS.
